// File: rtl/rst_seq_ctrl_if.sv
// Handshake bundle between the reset-release sequencer and its domains.
// master: the side that drives acks/requests and watches the reset outputs.
// slave : the sequencer itself.
interface rst_seq_ctrl_if #(
  parameter int NUM_DOMAINS = 4,
  parameter int FI_W        = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
);
  logic [NUM_DOMAINS-1:0] dom_ack;
  logic                   sw_rst_req;
  logic                   fault_clr;
  logic [NUM_DOMAINS-1:0] dom_rst_n;
  logic                   seq_done;
  logic                   seq_fault;
  logic [FI_W-1:0]        fault_idx;
  logic                   busy;

  modport master (
    output dom_ack, sw_rst_req, fault_clr,
    input  dom_rst_n, seq_done, seq_fault, fault_idx, busy
  );

  modport slave (
    input  dom_ack, sw_rst_req, fault_clr,
    output dom_rst_n, seq_done, seq_fault, fault_idx, busy
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset-release sequencer. Releases downstream domains one at a time in
// index order, each after a hold/gap, waiting for that domain's ack before
// moving on. A missing ack (optional timeout) parks the block in FAULT with
// the offending domain pushed back into reset. Everything is synchronous.
module rst_seq_ctrl #(
  parameter int NUM_DOMAINS = 4,
  parameter int GAP_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           sync_rst_n,
  rst_seq_ctrl_if.slave  bus
);
  localparam int FI_W    = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam bit               TO_EN    = (ACK_TIMEOUT > 0);
  localparam logic [FI_W-1:0]  LAST_IDX = FI_W'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {HOLD, WAIT_ACK, GAP, DONE, FAULT} state_t;

  state_t                 state, state_nxt;
  logic [FI_W-1:0]        idx, idx_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [NUM_DOMAINS-1:0] rst_q, rst_nxt;
  logic                   done_q, done_nxt;
  logic                   fault_q, fault_nxt;
  logic [FI_W-1:0]        fidx_q, fidx_nxt;
  logic                   busy_q, busy_nxt;

  // State and registered outputs; sync reset has top priority.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state   <= HOLD;
      idx     <= '0;
      cnt     <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      fidx_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      rst_q   <= rst_nxt;
      done_q  <= done_nxt;
      fault_q <= fault_nxt;
      fidx_q  <= fidx_nxt;
      busy_q  <= busy_nxt;
    end
  end

  // Next-state and next-output logic: restart requests first, then the FSM.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    rst_nxt   = rst_q;
    done_nxt  = done_q;
    fault_nxt = fault_q;
    fidx_nxt  = fidx_q;
    busy_nxt  = busy_q;

    if (bus.sw_rst_req || (bus.fault_clr && state == FAULT)) begin
      // Full re-sequence; a held request keeps cnt pinned at 0 in HOLD.
      state_nxt = HOLD;
      idx_nxt   = '0;
      cnt_nxt   = '0;
      rst_nxt   = '0;
      done_nxt  = 1'b0;
      fault_nxt = 1'b0;
      fidx_nxt  = '0;
      busy_nxt  = 1'b1;
    end else begin
      case (state)
        HOLD: begin
          busy_nxt = 1'b1;
          if (cnt == GAP_LAST) begin
            rst_nxt[0] = 1'b1;
            cnt_nxt    = '0;
            state_nxt  = WAIT_ACK;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        WAIT_ACK: begin
          // Ack on the timeout edge still counts as success.
          if (bus.dom_ack[idx]) begin
            cnt_nxt = '0;
            if (idx == LAST_IDX) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
              busy_nxt  = 1'b0;
            end else begin
              idx_nxt   = idx + FI_W'(1);
              state_nxt = GAP;
            end
          end else if (TO_EN && cnt == TO_LAST) begin
            // Timed-out domain goes back into reset; earlier ones stay out.
            rst_nxt[idx] = 1'b0;
            state_nxt    = FAULT;
            fault_nxt    = 1'b1;
            fidx_nxt     = idx;
            busy_nxt     = 1'b0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            rst_nxt[idx] = 1'b1;
            cnt_nxt      = '0;
            state_nxt    = WAIT_ACK;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        DONE:    ;
        FAULT:   ;
        default: state_nxt = HOLD;
      endcase
    end
  end

  assign bus.dom_rst_n = rst_q;
  assign bus.seq_done  = done_q;
  assign bus.seq_fault = fault_q;
  assign bus.fault_idx = fidx_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl (N=3, G=4, T=8, plus a T=0 instance).
// Expected outputs per edge come from release/ack/fault edge arithmetic,
// queued before each edge and checked 1 time unit after it.
module tb_rst_seq_ctrl;
  localparam int N = 3;
  localparam int G = 4;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_n2 = 1'b0;
  always #5 clk = ~clk;

  rst_seq_ctrl_if #(.NUM_DOMAINS(N)) bus ();
  rst_seq_ctrl_if #(.NUM_DOMAINS(N)) bus0 ();

  rst_seq_ctrl #(.NUM_DOMAINS(N), .GAP_CYCLES(G), .ACK_TIMEOUT(T)) dut (
    .clk(clk), .sync_rst_n(rst_n), .bus(bus));
  rst_seq_ctrl #(.NUM_DOMAINS(N), .GAP_CYCLES(G), .ACK_TIMEOUT(0)) dut0 (
    .clk(clk), .sync_rst_n(rst_n2), .bus(bus0));

  typedef struct packed {
    logic [N-1:0] rst;
    logic         done;
    logic         fault;
    logic [1:0]   fidx;
    logic         busy;
  } exp_t;

  typedef struct {
    int    l0, l1, l2;      // ack latency per domain (edges after release)
    int    done_e;          // edge seq_done rises, -1 if never
    int    fault_e;         // edge seq_fault rises, -1 if never
    int    fidx;
    int    fclr_e;          // edge to pulse fault_clr (no effect expected)
    string name;
  } vec_t;

  vec_t tbl[6];
  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat[N];
  int   age[N];
  bit   ack_off;

  function automatic exp_t model(input vec_t v, input int e);
    exp_t x;
    int   r;
    int   l[N];
    bit   stop;
    l = '{v.l0, v.l1, v.l2};
    x = '0;
    x.done  = (v.done_e >= 0) && (e >= v.done_e);
    x.fault = (v.fault_e >= 0) && (e >= v.fault_e);
    x.fidx  = x.fault ? 2'(v.fidx) : 2'd0;
    x.busy  = !(x.done || x.fault);
    r = G - 1;
    stop = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!stop) begin
        if (e >= r) x.rst[i] = 1'b1;
        if (l[i] > T) begin
          stop = 1'b1;
          if (x.fault) x.rst[i] = 1'b0;
        end else begin
          r = r + l[i] + G;
        end
      end
    end
    return x;
  endfunction

  task automatic tick(input exp_t x, input string tag, input int ed);
    exp_t got, w;
    q.push_back(x);
    for (int i = 0; i < N; i++) bus.dom_ack[i] = !ack_off && (age[i] >= lat[i]);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) age[i] = bus.dom_rst_n[i] ? age[i] + 1 : 0;
    got = {bus.dom_rst_n, bus.seq_done, bus.seq_fault, bus.fault_idx, bus.busy};
    w = q.pop_front();
    n_cmp++;
    if (got !== w) begin
      n_err++;
      $display("FAIL %s edge %0d: got rst=%b done=%b fault=%b fidx=%0d busy=%b, want rst=%b done=%b fault=%b fidx=%0d busy=%b",
               tag, ed, got.rst, got.done, got.fault, got.fidx, got.busy,
               w.rst, w.done, w.fault, w.fidx, w.busy);
    end
  endtask

  task automatic do_reset(input int n, input string tag);
    rst_n = 1'b0;
    for (int k = 0; k < n; k++) tick('0, tag, -1);
    rst_n = 1'b1;
  endtask

  task automatic restart(input bit sw, input int n, input string tag);
    exp_t r;
    r = '0;
    r.busy = 1'b1;
    for (int k = 0; k < n; k++) begin
      bus.sw_rst_req = sw;
      bus.fault_clr  = !sw;
      tick(r, tag, -1);
    end
    bus.sw_rst_req = 1'b0;
    bus.fault_clr  = 1'b0;
  endtask

  task automatic run_seq(input vec_t v, input int e0, input int e1);
    lat = '{v.l0, v.l1, v.l2};
    for (int e = e0; e <= e1; e++) begin
      ack_off = (v.done_e >= 0) && (e > v.done_e);
      bus.fault_clr = (e == v.fclr_e) || ((v.done_e >= 0) && (e == v.done_e + 2));
      tick(model(v, e), v.name, e);
    end
    bus.fault_clr = 1'b0;
    ack_off = 1'b0;
  endtask

  task automatic tick0(input exp_t x, input int ed);
    exp_t got, w;
    q.push_back(x);
    @(posedge clk);
    #1;
    got = {bus0.dom_rst_n, bus0.seq_done, bus0.seq_fault, bus0.fault_idx, bus0.busy};
    w = q.pop_front();
    n_cmp++;
    if (got !== w) begin
      n_err++;
      $display("FAIL no_timeout edge %0d: got %b want %b", ed, got, w);
    end
  endtask

  initial begin
    int   fin;
    exp_t x;
    bus.dom_ack = '0;  bus.sw_rst_req = 1'b0;  bus.fault_clr = 1'b0;
    bus0.dom_ack = '0; bus0.sw_rst_req = 1'b0; bus0.fault_clr = 1'b0;
    ack_off = 1'b0;
    for (int i = 0; i < N; i++) begin age[i] = 0; lat[i] = 1000; end

    //          l0  l1    l2  done fault fidx fclr name
    tbl[0] = '{ 2,  2,    2,  17,  -1,   0,   4,  "nominal"};
    tbl[1] = '{ 2,  1000, 2,  -1,  17,   1,  -1,  "fault_dom1"};
    tbl[2] = '{ 8,  2,    2,  23,  -1,   0,  -1,  "ack_at_timeout"};
    tbl[3] = '{ 9,  2,    2,  -1,  11,   0,  -1,  "ack_after_timeout"};
    tbl[4] = '{ 1,  1,    1,  14,  -1,   0,  -1,  "fastest_ack"};
    tbl[5] = '{ 3,  8,    1,  23,  -1,   0,  -1,  "mixed_lat"};

    do_reset(3, "reset");
    run_seq(tbl[0], 0, tbl[0].done_e + 3);
    restart(1'b1, 1, "sw_in_done");
    run_seq(tbl[0], 0, 20);

    for (int k = 1; k < 6; k++) begin
      restart(tbl[k-1].fault_e < 0, 1, (tbl[k-1].fault_e < 0) ? "sw_restart" : "fault_clr");
      fin = (tbl[k].done_e >= 0) ? tbl[k].done_e : tbl[k].fault_e;
      run_seq(tbl[k], 0, fin + 3);
    end

    restart(1'b1, 1, "sw_restart");
    run_seq(tbl[0], 0, 7);
    restart(1'b1, 1, "sw_in_gap");
    run_seq(tbl[0], 0, 20);

    restart(1'b1, 3, "sw_level");
    run_seq(tbl[0], 0, 20);

    restart(1'b1, 1, "sw_restart");
    run_seq(tbl[0], 0, 15);
    do_reset(2, "rst_mid_wait");
    run_seq(tbl[0], 0, 20);

    // Timeout disabled: no ack ever, block must sit in WAIT_ACK for domain 0.
    tick0('0, -1);
    rst_n2 = 1'b1;
    for (int e = 0; e < 40; e++) begin
      x = '0;
      x.busy = 1'b1;
      if (e >= G - 1) x.rst = 3'b001;
      tick0(x, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
